// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the sequential multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic x_signed;
    logic y_signed;
  } sign_mode_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - adds one group of shifted partial products into the accumulator
module mul_step #(
  parameter int PW = 16,
  parameter int K  = 2
) (
  input  logic [PW-1:0] acc_i,
  input  logic [K-1:0]  x_grp_i,
  input  logic [PW-1:0] y_i,
  input  logic          neg_last_i,
  output logic [PW-1:0] sum_o
);

  logic [PW-1:0] row;

  always_comb begin
    sum_o = acc_i;
    row   = '0;
    for (int j = 0; j < K; j++) begin
      row = x_grp_i[j] ? (y_i << j) : '0;
      // The sign bit of a two's-complement multiplier carries negative weight.
      if ((j == K - 1) && neg_last_i) sum_o = sum_o - row;
      else                            sum_o = sum_o + row;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - radix-2^K sequential multiplier with valid/ready handshakes
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH_X        = 8,
  parameter int WIDTH_Y        = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH_X-1:0]         x_i,
  input  logic [WIDTH_Y-1:0]         y_i,
  input  logic                       x_signed_i,
  input  logic                       y_signed_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH_X+WIDTH_Y-1:0] p_o
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = ceil_div(WIDTH_X, K);
  localparam int XE = N * K;
  localparam int PW = WIDTH_X + WIDTH_Y;
  localparam int CW = $clog2(N) + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [XE-1:0] x_q;
  logic [WIDTH_Y-1:0] y_q;
  sign_mode_t    mode_q;
  logic [PW-1:0] acc_q, p_q;

  logic          accept, last_step, neg_last;
  logic [XE-1:0] x_ext;
  logic [PW-1:0] y_ext, y_sh, step_sum;

  assign accept    = in_valid_i & in_ready_o;
  assign last_step = (state_q == BUSY) && (cnt_q == CW'(N - 1));
  assign neg_last  = mode_q.x_signed && (cnt_q == CW'(N - 1));

  // Extra top bit selects sign- or zero-extension in a single cast.
  assign x_ext = XE'($signed({x_signed_i & x_i[WIDTH_X-1], x_i}));
  assign y_ext = PW'($signed({mode_q.y_signed & y_q[WIDTH_Y-1], y_q}));
  assign y_sh  = y_ext << (32'(cnt_q) * K);

  mul_step #(.PW(PW), .K(K)) u_step (
    .acc_i      (acc_q),
    .x_grp_i    (x_q[K-1:0]),
    .y_i        (y_sh),
    .neg_last_i (neg_last),
    .sum_o      (step_sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_ready_i) state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
    out_valid_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= '0;
      acc_q  <= '0;
      p_q    <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      x_q    <= x_ext;
      y_q    <= y_i;
      mode_q <= '{x_signed: x_signed_i, y_signed: y_signed_i};
      acc_q  <= '0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CW'(1);
      x_q   <= x_q >> K;
      acc_q <= step_sum;
      if (last_step) p_q <= step_sum;
    end
  end

  assign p_o = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed and random checks for mul_seq
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, xs = 1'b0, ys = 1'b0;
  logic [7:0]  x = '0, y = '0;
  logic        in_ready, out_valid;
  logic [15:0] p;

  logic        in_valid3 = 1'b0, xs3 = 1'b0, ys3 = 1'b0;
  logic [7:0]  x3 = '0, y3 = '0;
  logic        in_ready3, out_valid3;
  logic [15:0] p3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH_X(8), .WIDTH_Y(8), .BITS_PER_CYCLE(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x_i(x), .y_i(y), .x_signed_i(xs), .y_signed_i(ys),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .p_o(p)
  );

  mul_seq #(.WIDTH_X(8), .WIDTH_Y(8), .BITS_PER_CYCLE(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .x_i(x3), .y_i(y3), .x_signed_i(xs3), .y_signed_i(ys3),
    .out_valid_o(out_valid3), .out_ready_i(1'b1), .p_o(p3)
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        xs;
    logic        ys;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic as, input logic bs);
    longint av, bv, pr;
    av = as ? longint'($signed(a)) : longint'(a);
    bv = bs ? longint'($signed(b)) : longint'(b);
    pr = av * bv;
    return pr[15:0];
  endfunction

  // Accepts one operand set, returns product and edges from accept to out_valid.
  task automatic run_op(input vec_t v, output logic [15:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    x = v.x; y = v.y; xs = v.xs; ys = v.ys; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; x = ~v.x; y = ~v.y; xs = ~v.xs; ys = ~v.ys;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = p;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t        vecs[8];
  vec_t        b2b[3];
  logic [15:0] res, held;
  logic [15:0] exp_q[$];
  int          lat, idx, nres, last_t, sent;
  logic        acc;
  localparam int NRAND = 10000;

  initial begin
    vecs[0] = '{8'h80, 8'h80, 1'b1, 1'b1, 16'h4000};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01};
    vecs[2] = '{8'hFE, 8'hFF, 1'b1, 1'b0, 16'hFE02};
    vecs[3] = '{8'hFF, 8'h80, 1'b0, 1'b1, 16'h8080};
    vecs[4] = '{8'h03, 8'hFB, 1'b1, 1'b1, 16'hFFF1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 1'b0, 16'h03A8};
    vecs[6] = '{8'h7F, 8'h81, 1'b1, 1'b1, 16'hC0FF};
    vecs[7] = '{8'h00, 8'hA5, 1'b1, 1'b1, 16'h0000};
    b2b[0]  = '{8'h05, 8'h07, 1'b0, 1'b0, 16'h0023};
    b2b[1]  = '{8'hFF, 8'h02, 1'b1, 1'b1, 16'hFFFE};
    b2b[2]  = '{8'h10, 8'h10, 1'b0, 1'b0, 16'h0100};

    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], res, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_p", i), 32'(res), 32'(vecs[i].p));
      drain();
      check($sformatf("vec%0d_released", i), 32'(out_valid), 32'd0);
    end

    run_op(vecs[2], res, lat);
    held = vecs[2].p;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_p", 32'(p), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    drain();

    in_valid = 1'b1; out_ready = 1'b1;
    x = b2b[0].x; y = b2b[0].y; xs = b2b[0].xs; ys = b2b[0].ys;
    idx = 0; nres = 0; last_t = -1;
    for (int c = 0; c < 40 && nres < 3; c++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        check($sformatf("b2b%0d_p", nres), 32'(p), 32'(b2b[nres].p));
        if (nres > 0) check("b2b_spacing", 32'(c - last_t), 32'd5);
        last_t = c;
        nres++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          x = b2b[idx].x; y = b2b[idx].y; xs = b2b[idx].xs; ys = b2b[idx].ys;
        end else in_valid = 1'b0;
      end
    end
    check("b2b_count", 32'(nres), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    x = 8'h55; y = 8'h33; xs = 1'b0; ys = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_valid", 32'(out_valid), 32'd0);
    check("rst_busy_p", 32'(p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      check("rst_no_stale_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_op(vecs[4], res, lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_p", 32'(res), 32'h0000FFF1);
    drain();

    sent = 0; nres = 0;
    x3 = 8'($urandom); y3 = 8'($urandom); xs3 = 1'($urandom); ys3 = 1'($urandom);
    exp_q.push_back(ref_mul(x3, y3, xs3, ys3));
    in_valid3 = 1'b1;
    for (int c = 0; c < 50000 && nres < NRAND; c++) begin
      acc = in_ready3 && in_valid3;
      if (out_valid3) begin
        if (exp_q.size() == 0) check("k3_unexpected_result", 32'd1, 32'd0);
        else check("k3_random_p", 32'(p3), 32'(exp_q.pop_front()));
        nres++;
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < NRAND) begin
          x3 = 8'($urandom); y3 = 8'($urandom); xs3 = 1'($urandom); ys3 = 1'($urandom);
          exp_q.push_back(ref_mul(x3, y3, xs3, ys3));
        end else in_valid3 = 1'b0;
      end
    end
    check("k3_result_count", 32'(nres), 32'(NRAND));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH_X, default 8, multiplier width, >=2.
REQ-002 SHALL have parameter WIDTH_Y, default 8, multiplicand width, >=2.
REQ-003 SHALL have parameter BITS_PER_CYCLE, default 2, multiplier bits retired per cycle, 1..WIDTH_X.
REQ-004 SHALL have port clk_i  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid_i  input  1  operand request valid.
REQ-007 SHALL have port in_ready_o  output  1  operands accepted when high with in_valid_i.
REQ-008 SHALL have port x_i  input  WIDTH_X  multiplier.
REQ-009 SHALL have port y_i  input  WIDTH_Y  multiplicand.
REQ-010 SHALL have port x_signed_i  input  1  x_i is two's complement (1) or unsigned (0).
REQ-011 SHALL have port y_signed_i  input  1  y_i is two's complement (1) or unsigned (0).
REQ-012 SHALL have port out_valid_o  output  1  product valid.
REQ-013 SHALL have port out_ready_i  input  1  consumer accepts product.
REQ-014 SHALL have port p_o  output  WIDTH_X+WIDTH_Y  product.

Function
REQ-015 SHALL define N = ceil(WIDTH_X/BITS_PER_CYCLE); x_i extended to N*BITS_PER_CYCLE bits per x_signed_i (sign- or zero-extend).
REQ-016 SHALL implement FSM IDLE -> BUSY on accept; BUSY -> DONE when step counter reaches N-1; DONE -> IDLE on out_ready_i, or DONE -> BUSY on out_ready_i with simultaneous accept.
REQ-017 SHALL drive in_ready_o = (state==IDLE) | (state==DONE & out_ready_i).
REQ-018 SHALL latch x_i, y_i, both sign flags on the accepting edge; later input changes have no effect.
REQ-019 SHALL each BUSY cycle add BITS_PER_CYCLE partial products (y extended per y_signed_i to full width, shifted) into the accumulator, LSB group first.
REQ-020 SHALL, when x_signed, weight the final group's MSB partial product negatively (subtract), yielding exact two's-complement result.
REQ-021 SHALL assert out_valid_o exactly N edges after the accepting edge, p_o = product modulo 2^(WIDTH_X+WIDTH_Y), all four sign modes.
REQ-022 SHALL hold out_valid_o and p_o stable while out_valid_o & !out_ready_i.
REQ-023 SHALL sustain one product per N+1 cycles under back-to-back traffic with out_ready_i tied high.
REQ-024 SHALL leave p_o unchanged outside DONE (last result held; don't-care for checker).

Reset
REQ-025 SHALL on rst_ni low, immediately: state IDLE, counter 0, accumulator 0, out_valid_o 0, p_o 0, in_ready_o 1 once released.
REQ-026 SHALL discard any in-flight operation on reset mid-BUSY or mid-DONE; no out_valid_o after release without new accept.

Structure
REQ-027 SHALL place state enum (IDLE, BUSY, DONE) and a sign-mode struct {x_signed, y_signed} in shared package mul_pkg.
REQ-028 SHALL use one sub-module mul_step: combinational BITS_PER_CYCLE-row partial-product generate and add, with negate-last-row control.
REQ-029 SHALL be synthesizable with no latches; counter width $clog2(N)+1.

Verification
REQ-030 SHALL cover 8x8, K=2, signed/signed: x=0x80, y=0x80 -> p=0x4000 after 4 edges.
REQ-031 SHALL cover unsigned/unsigned: x=0xFF, y=0xFF -> p=0xFE01; signed x, unsigned y: x=0xFE, y=0xFF -> p=0xFE02.
REQ-032 SHALL cover backpressure: out_ready_i low 5 cycles after out_valid_o -> p_o, out_valid_o stable, in_ready_o low.
REQ-033 SHALL cover back-to-back: 3 requests, out_ready_i high -> results every 5 cycles, correct order.
REQ-034 SHALL cover reset asserted in BUSY cycle 2 -> outputs zero, no stale out_valid_o; next op x=3,y=-5 signed -> 0xFFF1.
REQ-035 SHALL cover K=3, WIDTH_X=8 (N=3), 10000 random operands and modes vs. reference model.
